// File: rtl/cp0_ctrl.sv
// CP0 system-control block: Count/Compare timer, Status/Cause/EPC/BadVAddr, MFC0 read mux.
// Define CP0_TIMER_EN to build the Compare register and timer interrupt.
module cp0_ctrl #(
    parameter int          NUM_HW_INT   = 6,
    parameter int          COUNT_DIV    = 2,
    parameter logic [31:0] EXC_VECTOR   = 32'hBFC00380,
    parameter logic [31:0] PRID_VALUE   = 32'h004C0102,
    parameter logic [31:0] CONFIG_VALUE = 32'h00008000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we_i,
    input  logic [4:0]            waddr_i,
    input  logic [31:0]           wdata_i,
    input  logic [4:0]            raddr_i,
    output logic [31:0]           rdata_o,
    input  logic [NUM_HW_INT-1:0] int_i,
    input  logic                  exc_valid_i,
    input  logic [4:0]            exc_code_i,
    input  logic                  eret_i,
    input  logic [31:0]           exc_pc_i,
    input  logic                  in_delayslot_i,
    input  logic [31:0]           bad_addr_i,
    output logic [31:0]           status_o,
    output logic [31:0]           cause_o,
    output logic [31:0]           epc_o,
    output logic [31:0]           count_o,
    output logic                  int_req_o,
    output logic                  timer_int_o,
    output logic [31:0]           target_pc_o
);

    localparam logic [4:0] R_BADV   = 5'd8;
    localparam logic [4:0] R_COUNT  = 5'd9;
    localparam logic [4:0] R_CMP    = 5'd11;
    localparam logic [4:0] R_STATUS = 5'd12;
    localparam logic [4:0] R_CAUSE  = 5'd13;
    localparam logic [4:0] R_EPC    = 5'd14;
    localparam logic [4:0] R_PRID   = 5'd15;
    localparam logic [4:0] R_CONFIG = 5'd16;
    localparam logic [3:0] DIV_LAST = 4'(COUNT_DIV - 1);

    logic [31:0]           count_q, badv_q, epc_q, compare_rd;
    logic [3:0]            pre_q;
    logic [7:0]            im_q;
    logic                  exl_q, ie_q, bd_q, int_req_q;
    logic [4:0]            exccode_q;
    logic [1:0]            ip_sw_q;
    logic [NUM_HW_INT-1:0] ip_hw_q;
    logic [7:0]            ip;
    logic                  wr_count, wr_status, wr_cause, wr_epc;

    assign wr_count  = we_i && (waddr_i == R_COUNT);
    assign wr_status = we_i && (waddr_i == R_STATUS);
    assign wr_cause  = we_i && (waddr_i == R_CAUSE);
    assign wr_epc    = we_i && (waddr_i == R_EPC);

`ifdef CP0_TIMER_EN
    logic [31:0] compare_q;
    logic        timer_q;
    logic        wr_compare;

    assign wr_compare = we_i && (waddr_i == R_CMP);

    // Match uses pre-edge Count/Compare; a Compare write both clears and masks a match.
    always_ff @(posedge clk) begin
        if (rst) begin
            compare_q <= '0;
            timer_q   <= 1'b0;
        end else if (wr_compare) begin
            compare_q <= wdata_i;
            timer_q   <= 1'b0;
        end else if (count_q == compare_q) begin
            timer_q   <= 1'b1;
        end
    end

    assign compare_rd  = compare_q;
    assign timer_int_o = timer_q;
`else
    assign compare_rd  = '0;
    assign timer_int_o = 1'b0;
`endif

    // Cause.IP[15:8] as an 8-bit vector; hardware lines start at IP[10].
    always_comb begin
        ip                   = '0;
        ip[1:0]              = ip_sw_q;
        ip[2 +: NUM_HW_INT]  = ip_hw_q;
        ip[7]                = ip[7] | timer_int_o;
    end

    assign status_o    = {9'b0, 1'b1, 6'b0, im_q, 6'b0, exl_q, ie_q};
    assign cause_o     = {bd_q, timer_int_o, 14'b0, ip, 1'b0, exccode_q, 2'b0};
    assign epc_o       = epc_q;
    assign count_o     = count_q;
    assign int_req_o   = int_req_q;
    assign target_pc_o = eret_i ? epc_q : EXC_VECTOR;

    always_comb begin
        case (raddr_i)
            R_BADV:   rdata_o = badv_q;
            R_COUNT:  rdata_o = count_q;
            R_CMP:    rdata_o = compare_rd;
            R_STATUS: rdata_o = status_o;
            R_CAUSE:  rdata_o = cause_o;
            R_EPC:    rdata_o = epc_q;
            R_PRID:   rdata_o = PRID_VALUE;
            R_CONFIG: rdata_o = CONFIG_VALUE;
            default:  rdata_o = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q   <= '0;
            pre_q     <= '0;
            badv_q    <= '0;
            epc_q     <= '0;
            im_q      <= '0;
            exl_q     <= 1'b0;
            ie_q      <= 1'b0;
            bd_q      <= 1'b0;
            exccode_q <= '0;
            ip_sw_q   <= '0;
            ip_hw_q   <= '0;
            int_req_q <= 1'b0;
        end else begin
            ip_hw_q   <= int_i;
            int_req_q <= (|(ip & im_q)) & ie_q & ~exl_q;

            if (wr_count) begin
                count_q <= wdata_i;
                pre_q   <= '0;
            end else if (pre_q == DIV_LAST) begin
                pre_q   <= '0;
                count_q <= count_q + 32'd1;
            end else begin
                pre_q   <= pre_q + 4'd1;
            end

            // IM/IE and software IP never collide with exception/ERET fields.
            if (wr_status) begin
                im_q <= wdata_i[15:8];
                ie_q <= wdata_i[0];
            end
            if (wr_cause)
                ip_sw_q <= wdata_i[9:8];

            if (exc_valid_i) begin
                if (!exl_q) begin
                    epc_q <= in_delayslot_i ? exc_pc_i - 32'd4 : exc_pc_i;
                    bd_q  <= in_delayslot_i;
                end
                exl_q     <= 1'b1;
                exccode_q <= exc_code_i;
                if (exc_code_i == 5'd4 || exc_code_i == 5'd5)
                    badv_q <= bad_addr_i;
            end else begin
                if (eret_i)
                    exl_q <= 1'b0;
                else if (wr_status)
                    exl_q <= wdata_i[1];
                if (wr_epc)
                    epc_q <= wdata_i;
            end
        end
    end

endmodule
